dmem_vector_reader: RTL and testbench

Read-side companion to the data memory. Accepts scalar (1-word) or vector (6-word) load requests. Issues sequential single-word reads to a synchronous 1-cycle-latency RAM read port. Packs the returned words into a V-bit response using the same lane order the memory uses for vector writes (lane k = word at address+k, bits [(k+1)*S-1:k*S]), and returns it over a valid/ready handshake to the vector/scalar load path.

---
 rtl/dmem_vector_reader.sv | 161 ++++++++++++++++
 tb/tb_dmem_vector_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_vector_reader.sv
// Load-side reader for the data memory: issues 1 or 6 sequential word reads to a
// 1-cycle-latency RAM port and returns the packed lanes over a valid/ready handshake.
module dmem_vector_reader #(
   parameter int S    = 32,
   parameter int V    = 192,
   parameter int SIZE = 30000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_isVector,
   input  logic [S-1:0] req_address,
   output logic         mem_re,
   output logic [S-1:0] mem_addr,
   input  logic [S-1:0] mem_rdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [V-1:0] resp_data,
   output logic         resp_err
);

   localparam int LANES = V / S;
   localparam int KW    = $clog2(LANES);

   // FLUSH is the cycle the RAM samples the last address; DRAIN captures its data.
   typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, DRAIN, RESP} state_t;

   state_t          state_r, state_nxt_s;
   logic [S-1:0]    base_r, base_nxt_s;
   logic [KW-1:0]   last_r, last_nxt_s;
   logic [KW-1:0]   k_r, k_nxt_s;
   logic            mem_re_r, mem_re_nxt_s;
   logic [S-1:0]    mem_addr_r, mem_addr_nxt_s;
   logic [KW-1:0]   lane_r, lane_nxt_s;
   logic            rd_pend_r, rd_pend_nxt_s;
   logic [KW-1:0]   rd_lane_r, rd_lane_nxt_s;
   logic [V-1:0]    data_r, data_nxt_s;
   logic            err_r, err_nxt_s;
   logic            req_ready_r, req_ready_nxt_s;
   logic            resp_valid_r, resp_valid_nxt_s;

   // Carry out of S bits lands in the top bit and is therefore out of range.
   logic [S:0]      addr_ext_s;
   logic            in_range_s;

   assign addr_ext_s = {1'b0, base_r} + {{(S+1-KW){1'b0}}, k_r};
   assign in_range_s = (addr_ext_s < (S+1)'(SIZE));

   assign req_ready  = req_ready_r;
   assign mem_re     = mem_re_r;
   assign mem_addr   = mem_addr_r;
   assign resp_valid = resp_valid_r;
   assign resp_data  = data_r;
   assign resp_err   = err_r;

   // Next-state and next-register computation for the whole reader.
   always_comb begin
      state_nxt_s      = state_r;
      base_nxt_s       = base_r;
      last_nxt_s       = last_r;
      k_nxt_s          = k_r;
      mem_re_nxt_s     = 1'b0;
      mem_addr_nxt_s   = mem_addr_r;
      lane_nxt_s       = lane_r;
      rd_pend_nxt_s    = mem_re_r;
      rd_lane_nxt_s    = lane_r;
      data_nxt_s       = data_r;
      err_nxt_s        = err_r;
      req_ready_nxt_s  = req_ready_r;
      resp_valid_nxt_s = resp_valid_r;

      if (rd_pend_r) begin
         data_nxt_s[int'(rd_lane_r)*S +: S] = mem_rdata;
      end else begin
         data_nxt_s = data_r;
      end

      case (state_r)
         IDLE: begin
            if (req_valid && req_ready_r) begin
               base_nxt_s      = req_address;
               last_nxt_s      = req_isVector ? KW'(LANES-1) : {KW{1'b0}};
               k_nxt_s         = {KW{1'b0}};
               data_nxt_s      = {V{1'b0}};
               err_nxt_s       = 1'b0;
               req_ready_nxt_s = 1'b0;
               state_nxt_s     = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            mem_re_nxt_s   = in_range_s;
            mem_addr_nxt_s = addr_ext_s[S-1:0];
            lane_nxt_s     = k_r;
            err_nxt_s      = err_r | ~in_range_s;
            if (k_r == last_r) begin
               state_nxt_s = FLUSH;
            end else begin
               k_nxt_s = k_r + KW'(1);
            end
         end
         FLUSH: begin
            state_nxt_s = DRAIN;
         end
         DRAIN: begin
            resp_valid_nxt_s = 1'b1;
            state_nxt_s      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_nxt_s = 1'b0;
               req_ready_nxt_s  = 1'b1;
               state_nxt_s      = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            resp_valid_nxt_s = 1'b0;
            req_ready_nxt_s  = 1'b1;
            state_nxt_s      = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset also drops any read still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         base_r       <= {S{1'b0}};
         last_r       <= {KW{1'b0}};
         k_r          <= {KW{1'b0}};
         mem_re_r     <= 1'b0;
         mem_addr_r   <= {S{1'b0}};
         lane_r       <= {KW{1'b0}};
         rd_pend_r    <= 1'b0;
         rd_lane_r    <= {KW{1'b0}};
         data_r       <= {V{1'b0}};
         err_r        <= 1'b0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         base_r       <= base_nxt_s;
         last_r       <= last_nxt_s;
         k_r          <= k_nxt_s;
         mem_re_r     <= mem_re_nxt_s;
         mem_addr_r   <= mem_addr_nxt_s;
         lane_r       <= lane_nxt_s;
         rd_pend_r    <= rd_pend_nxt_s;
         rd_lane_r    <= rd_lane_nxt_s;
         data_r       <= data_nxt_s;
         err_r        <= err_nxt_s;
         req_ready_r  <= req_ready_nxt_s;
         resp_valid_r <= resp_valid_nxt_s;
      end
   end

endmodule

// File: tb/tb_dmem_vector_reader.sv
// Directed bench for dmem_vector_reader with a behavioural 1-cycle-latency RAM.
module tb_dmem_vector_reader;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_isVector;
   logic [31:0]   req_address;
   logic          mem_re;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_rdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [191:0]  resp_data;
   logic          resp_err;

   logic [31:0]   ram [0:29999];
   int            checks   = 0;
   int            failures = 0;
   logic [191:0]  held_data;

   dmem_vector_reader #(.S(32), .V(192), .SIZE(30000)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_isVector(req_isVector), .req_address(req_address),
      .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) begin
         mem_rdata <= (mem_addr < 32'd30000) ? ram[mem_addr] : 32'hBAD0BAD0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it cycle by cycle up to the response.
   task automatic load(input logic [31:0] addr, input logic vec, input logic [5:0] exp_re,
                       input logic [191:0] exp_d, input logic exp_e);
      int n;
      n = vec ? 6 : 1;
      req_valid    = 1'b1;
      req_address  = addr;
      req_isVector = vec;
      chk("req_ready_idle", {191'd0, req_ready}, 192'd1);
      tick();
      req_valid   = 1'b0;
      req_address = 32'h5555_5555;
      chk("req_ready_busy", {191'd0, req_ready}, 192'd0);
      chk("mem_re_e0", {191'd0, mem_re}, 192'd0);
      for (int k = 0; k < n; k++) begin
         tick();
         chk("mem_re_issue", {191'd0, mem_re}, {191'd0, exp_re[k]});
         if (exp_re[k]) chk("mem_addr_issue", {160'd0, mem_addr}, {160'd0, addr + 32'(k)});
         chk("resp_valid_early", {191'd0, resp_valid}, 192'd0);
      end
      tick();
      chk("mem_re_flush", {191'd0, mem_re}, 192'd0);
      chk("resp_valid_flush", {191'd0, resp_valid}, 192'd0);
      tick();
      chk("resp_valid_rise", {191'd0, resp_valid}, 192'd1);
      chk("resp_data", resp_data, exp_d);
      chk("resp_err", {191'd0, resp_err}, {191'd0, exp_e});
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("resp_valid_drop", {191'd0, resp_valid}, 192'd0);
      chk("req_ready_back", {191'd0, req_ready}, 192'd1);
   endtask

   initial begin
      ram[100] = 32'hDEADBEEF;
      ram[300] = 32'h12345678;
      for (int i = 0; i < 6; i++) ram[200 + i] = 32'(i + 1);
      ram[29997] = 32'h0000000A;
      ram[29998] = 32'h0000000B;
      ram[29999] = 32'h0000000C;

      reset = 1'b1; req_valid = 1'b0; req_isVector = 1'b0; req_address = 32'd0; resp_ready = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", {191'd0, req_ready}, 192'd1);
      chk("rst_mem_re", {191'd0, mem_re}, 192'd0);
      chk("rst_mem_addr", {160'd0, mem_addr}, 192'd0);
      chk("rst_resp_valid", {191'd0, resp_valid}, 192'd0);
      chk("rst_resp_data", resp_data, 192'd0);
      chk("rst_resp_err", {191'd0, resp_err}, 192'd0);
      reset = 1'b0;
      tick();

      // Scalar and vector loads in range
      load(32'd100, 1'b0, 6'b000001, {160'd0, 32'hDEADBEEF}, 1'b0);
      handshake();
      load(32'd200, 1'b1, 6'b111111,
           {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
      handshake();

      // Upper boundary: partial vector and scalar just past the end
      load(32'd29997, 1'b1, 6'b000111, {96'd0, 32'h0000000C, 32'h0000000B, 32'h0000000A}, 1'b1);
      handshake();
      load(32'd30000, 1'b0, 6'b000000, 192'd0, 1'b1);
      handshake();

      // Backpressure with a competing request held high
      load(32'd300, 1'b0, 6'b000001, {160'd0, 32'h12345678}, 1'b0);
      held_data = {160'd0, 32'h12345678};
      req_valid = 1'b1; req_address = 32'd100; req_isVector = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_resp_valid", {191'd0, resp_valid}, 192'd1);
         chk("bp_resp_data", resp_data, held_data);
         chk("bp_req_ready", {191'd0, req_ready}, 192'd0);
         chk("bp_mem_re", {191'd0, mem_re}, 192'd0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("bp_drop", {191'd0, resp_valid}, 192'd0);
      chk("bp_ready_next", {191'd0, req_ready}, 192'd1);
      chk("bp_no_issue", {191'd0, mem_re}, 192'd0);
      load(32'd200, 1'b1, 6'b111111,
           {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
      handshake();

      // Reset after three issued reads of a vector
      req_valid = 1'b1; req_address = 32'd200; req_isVector = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_mem_re", {191'd0, mem_re}, 192'd1);
      chk("mid_mem_addr", {160'd0, mem_addr}, {160'd0, 32'd202});
      reset = 1'b1;
      #1;
      chk("async_resp_valid", {191'd0, resp_valid}, 192'd0);
      chk("async_mem_re", {191'd0, mem_re}, 192'd0);
      chk("async_req_ready", {191'd0, req_ready}, 192'd1);
      chk("async_resp_data", resp_data, 192'd0);
      tick();
      reset = 1'b0;
      load(32'd100, 1'b0, 6'b000001, {160'd0, 32'hDEADBEEF}, 1'b0);
      handshake();

      // Address overflow past 32 bits
      load(32'hFFFFFFFE, 1'b1, 6'b000000, 192'd0, 1'b1);
      handshake();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
